// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - register-file write scoreboard between ID and WB
module regfile_scoreboard #(
  parameter int REG_NUM      = 32,
  parameter int REG_ADDR_LEN = 5,
  parameter int CNT_W        = 2,
  parameter int INF_W        = 7,
  parameter int STAT_W       = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    issue_valid,
  input  logic [REG_ADDR_LEN-1:0] issue_rs1,
  input  logic                    issue_rs1_used,
  input  logic [REG_ADDR_LEN-1:0] issue_rs2,
  input  logic                    issue_rs2_used,
  input  logic [REG_ADDR_LEN-1:0] issue_rd,
  input  logic                    issue_we,
  output logic                    issue_ready,
  input  logic                    wb_valid,
  input  logic                    wb_we,
  input  logic [REG_ADDR_LEN-1:0] wb_rd,
  output logic                    rf_read_en,
  output logic                    rf_write_en,
  output logic [REG_NUM-1:0]      busy_vec,
  output logic [INF_W-1:0]        inflight,
  output logic                    err_underflow,
  output logic [STAT_W-1:0]       stall_cycles
);

  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

  // Per-register count of writes issued but not yet retired.
  logic [CNT_W-1:0] cnt [REG_NUM];

  logic raw1, raw2, sat, fire, inc, dec, dec_hit;

  // Hazard detection looks only at the counters and the ID inputs; a release in
  // WB this cycle is deliberately not bypassed because the register file only
  // commits on the clock edge.
  always_comb begin
    raw1        = issue_rs1_used && (issue_rs1 != '0) && (cnt[issue_rs1] != '0);
    raw2        = issue_rs2_used && (issue_rs2 != '0) && (cnt[issue_rs2] != '0);
    sat         = issue_we && (issue_rd != '0) && (cnt[issue_rd] == CNT_MAX);
    issue_ready = !(raw1 || raw2 || sat);
    fire        = issue_valid && issue_ready;
    rf_read_en  = fire;
    rf_write_en = wb_valid && wb_we;
    inc         = fire && issue_we && (issue_rd != '0);
    dec         = wb_valid && wb_we && (wb_rd != '0);
    dec_hit     = dec && (cnt[wb_rd] != '0);
  end

  // Busy flags are a direct view of the counters; register 0 is never busy.
  always_comb begin
    busy_vec = '0;
    for (int r = 1; r < REG_NUM; r++) begin
      busy_vec[r] = (cnt[r] != '0);
    end
  end

  // Per-register counters: +1 on issue, -1 on release of a live write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < REG_NUM; r++) begin
        cnt[r] <= '0;
      end
    end else begin
      cnt[0] <= '0;
      for (int r = 1; r < REG_NUM; r++) begin
        if (inc && (issue_rd == REG_ADDR_LEN'(r)) &&
            !(dec_hit && (wb_rd == REG_ADDR_LEN'(r)))) begin
          cnt[r] <= cnt[r] + 1'b1;
        end else if (dec_hit && (wb_rd == REG_ADDR_LEN'(r)) &&
                     !(inc && (issue_rd == REG_ADDR_LEN'(r)))) begin
          cnt[r] <= cnt[r] - 1'b1;
        end
      end
    end
  end

  // Total in-flight count tracks the same net delta; an underflowing release
  // changes nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
    end else if (inc && !dec_hit) begin
      inflight <= inflight + 1'b1;
    end else if (dec_hit && !inc) begin
      inflight <= inflight - 1'b1;
    end
  end

  // Sticky flag for a release that had no matching outstanding write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_underflow <= 1'b0;
    end else if (dec && !dec_hit) begin
      err_underflow <= 1'b1;
    end
  end

  // Saturating count of cycles where ID held a valid instruction back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (issue_valid && !issue_ready && (stall_cycles != STAT_MAX)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule
